// File: rtl/pll_lock_sequencer.sv
// PLL restart / lock qualification sequencer running on the board reference clock.
// Holds the PLL in reset, waits for a stable lock, and releases downstream reset.
module pll_lock_sequencer #(
    parameter int unsigned RESET_CYCLES        = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter logic [5:0]  DEF_IDSEL           = 6'd0,
    parameter logic [5:0]  DEF_FBDSEL          = 6'd0,
    parameter logic [5:0]  DEF_ODSEL           = 6'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       cfg_valid,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    output logic       cfg_ready,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       sys_rst,
    output logic       locked,
    output logic       fault,
    output logic [3:0] retry_count
);

    localparam int unsigned MAX_RS =
        (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_CNT =
        (MAX_RS > LOCK_TIMEOUT_CYCLES) ? MAX_RS : LOCK_TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [1:0]    sync;
    logic          lock_sync;
    logic [3:0]    retry_inc;
    logic          cfg_fire;

    assign lock_sync = sync[1];
    assign cfg_ready = (state == S_RUN) || (state == S_FAULT);
    assign cfg_fire  = cfg_valid && cfg_ready;

    // Saturating increments: counters hold at all-ones rather than wrap.
    always_comb begin
        cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
        retry_inc = (retry_count == 4'hF) ? retry_count : retry_count + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RESET_PLL;
            cnt         <= '0;
            sync        <= 2'b00;
            pll_reset   <= 1'b1;
            sys_rst     <= 1'b1;
            locked      <= 1'b0;
            fault       <= 1'b0;
            retry_count <= 4'd0;
            pll_idsel   <= DEF_IDSEL;
            pll_fbdsel  <= DEF_FBDSEL;
            pll_odsel   <= DEF_ODSEL;
        end else begin
            sync <= {sync[0], pll_lock};
            unique case (state)
                S_RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        state     <= S_WAIT_LOCK;
                        cnt       <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_sync) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TMO_LAST) begin
                        retry_count <= retry_inc;
                        cnt         <= '0;
                        pll_reset   <= 1'b1;
                        if (retry_inc == RETRY_LIM) begin
                            state <= S_FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= S_RESET_PLL;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_STABLE: begin
                    if (!lock_sync) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STB_LAST) begin
                        state       <= S_RUN;
                        cnt         <= '0;
                        sys_rst     <= 1'b0;
                        locked      <= 1'b1;
                        retry_count <= 4'd0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_RUN: begin
                    // A new profile wins over lock loss; both restart the PLL once.
                    if (cfg_fire || !lock_sync) begin
                        state     <= S_RESET_PLL;
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        sys_rst   <= 1'b1;
                        locked    <= 1'b0;
                    end
                    if (cfg_fire) begin
                        pll_idsel  <= cfg_idsel;
                        pll_fbdsel <= cfg_fbdsel;
                        pll_odsel  <= cfg_odsel;
                    end
                end
                S_FAULT: begin
                    if (cfg_fire) begin
                        state       <= S_RESET_PLL;
                        cnt         <= '0;
                        fault       <= 1'b0;
                        retry_count <= 4'd0;
                        pll_idsel   <= cfg_idsel;
                        pll_fbdsel  <= cfg_fbdsel;
                        pll_odsel   <= cfg_odsel;
                    end
                end
                default: begin
                    state     <= S_RESET_PLL;
                    cnt       <= '0;
                    pll_reset <= 1'b1;
                    sys_rst   <= 1'b1;
                    locked    <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomized bench for pll_lock_sequencer against a timestamp-based reference model.
// Phases are tracked by entry edge number; lock_sync is a delayed sample history.
module tb_pll_lock_sequencer;

    localparam int R = 4;
    localparam int S = 8;
    localparam int T = 32;
    localparam int M = 2;
    localparam logic [5:0] D_ID = 6'd3;
    localparam logic [5:0] D_FB = 6'd17;
    localparam logic [5:0] D_OD = 6'd1;
    localparam int NCYC = 6000;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STB  = 2;
    localparam int P_RUN  = 3;
    localparam int P_FLT  = 4;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       cfg_valid;
    logic [5:0] cfg_idsel;
    logic [5:0] cfg_fbdsel;
    logic [5:0] cfg_odsel;
    logic       cfg_ready;
    logic       pll_reset;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       sys_rst;
    logic       locked;
    logic       fault;
    logic [3:0] retry_count;

    pll_lock_sequencer #(
        .RESET_CYCLES(R),
        .LOCK_STABLE_CYCLES(S),
        .LOCK_TIMEOUT_CYCLES(T),
        .MAX_RETRIES(M),
        .DEF_IDSEL(D_ID),
        .DEF_FBDSEL(D_FB),
        .DEF_ODSEL(D_OD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pll_lock(pll_lock),
        .cfg_valid(cfg_valid),
        .cfg_idsel(cfg_idsel),
        .cfg_fbdsel(cfg_fbdsel),
        .cfg_odsel(cfg_odsel),
        .cfg_ready(cfg_ready),
        .pll_reset(pll_reset),
        .pll_idsel(pll_idsel),
        .pll_fbdsel(pll_fbdsel),
        .pll_odsel(pll_odsel),
        .sys_rst(sys_rst),
        .locked(locked),
        .fault(fault),
        .retry_count(retry_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int       phase = P_RST;
    longint   cur = 0;
    longint   entry = 0;
    int       m_retry = 0;
    int       m_id = 0;
    int       m_fb = 0;
    int       m_od = 0;
    bit       seen[$];
    int       n_run = 0;
    int       n_flt = 0;

    task automatic enter(input int p);
        phase = p;
        entry = cur;
    endtask

    task automatic model_step();
        bit lsync;
        longint k;
        cur++;
        if (rst) begin
            enter(P_RST);
            m_retry = 0;
            m_id = D_ID;
            m_fb = D_FB;
            m_od = D_OD;
            seen.delete();
            return;
        end
        // lock_sync seen at this edge is pll_lock from two edges earlier
        lsync = (seen.size() >= 2) ? seen[seen.size()-2] : 1'b0;
        seen.push_back(pll_lock);
        if (seen.size() > 4) void'(seen.pop_front());
        k = cur - entry;
        case (phase)
            P_RST: if (k == R) enter(P_WAIT);
            P_WAIT: begin
                if (lsync) enter(P_STB);
                else if (k == T) begin
                    if (m_retry < 15) m_retry++;
                    if (m_retry == M) begin
                        enter(P_FLT);
                        n_flt++;
                    end else enter(P_RST);
                end
            end
            P_STB: begin
                if (!lsync) enter(P_WAIT);
                else if (k == S) begin
                    enter(P_RUN);
                    m_retry = 0;
                    n_run++;
                end
            end
            P_RUN: begin
                if (cfg_valid) begin
                    m_id = cfg_idsel;
                    m_fb = cfg_fbdsel;
                    m_od = cfg_odsel;
                    enter(P_RST);
                end else if (!lsync) enter(P_RST);
            end
            P_FLT: begin
                if (cfg_valid) begin
                    m_id = cfg_idsel;
                    m_fb = cfg_fbdsel;
                    m_od = cfg_odsel;
                    m_retry = 0;
                    enter(P_RST);
                end
            end
            default: enter(P_RST);
        endcase
    endtask

    task automatic check_all();
        chk("pll_reset", 32'(pll_reset), 32'(phase == P_RST || phase == P_FLT));
        chk("sys_rst", 32'(sys_rst), 32'(phase != P_RUN));
        chk("locked", 32'(locked), 32'(phase == P_RUN));
        chk("fault", 32'(fault), 32'(phase == P_FLT));
        chk("cfg_ready", 32'(cfg_ready), 32'(phase == P_RUN || phase == P_FLT));
        chk("retry_count", 32'(retry_count), 32'(m_retry));
        chk("pll_idsel", 32'(pll_idsel), 32'(m_id));
        chk("pll_fbdsel", 32'(pll_fbdsel), 32'(m_fb));
        chk("pll_odsel", 32'(pll_odsel), 32'(m_od));
    endtask

    int seg_left = 0;
    int seg_mode = 0;

    task automatic drive_next(input int i);
        if (seg_left == 0) begin
            seg_mode = $urandom_range(0, 2);
            case (seg_mode)
                0: seg_left = $urandom_range(15, 80);
                1: seg_left = $urandom_range(20, 120);
                default: seg_left = $urandom_range(5, 30);
            endcase
        end
        seg_left--;
        case (seg_mode)
            0: pll_lock = ($urandom_range(0, 39) != 0);
            1: pll_lock = 1'b0;
            default: pll_lock = 1'($urandom_range(0, 1));
        endcase
        cfg_valid  = ($urandom_range(0, 15) == 0);
        cfg_idsel  = 6'($urandom);
        cfg_fbdsel = 6'($urandom);
        cfg_odsel  = 6'($urandom);
        rst = (i < 3) || ($urandom_range(0, 299) == 0);
    endtask

    initial begin
        rst        = 1'b1;
        pll_lock   = 1'b0;
        cfg_valid  = 1'b0;
        cfg_idsel  = 6'd0;
        cfg_fbdsel = 6'd0;
        cfg_odsel  = 6'd0;
        for (int i = 0; i < NCYC; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
            drive_next(i);
        end
        chk("reached_run", 32'(n_run > 0), 32'd1);
        chk("reached_fault", 32'(n_flt > 0), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
